// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 echo emulator and the ultrasonic controller:
// FSM states, distance scaling constants and default timing derived from the clock.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    BURST,
    ECHO,
    HOLDOFF
  } state_e;

  localparam int CLK_HZ = 50_000_000;

  // Echo cycles per mm = SCALE_NUM / SCALE_DEN (round trip at ~340 m/s on a 50 MHz clock)
  localparam int SCALE_NUM = 10_000;
  localparam int SCALE_DEN = 34;

  localparam int NUM_W = 26;
  localparam int QUO_W = 21;

  localparam int DEF_MIN_TRIG_CYCLES     = CLK_HZ / 100_000;
  localparam int DEF_BURST_DELAY_CYCLES  = CLK_HZ / 5_000;
  localparam int DEF_MAX_DIST_MM         = 4000;
  localparam int DEF_TIMEOUT_ECHO_CYCLES = CLK_HZ / 1000 * 38;
  localparam int DEF_HOLDOFF_CYCLES      = CLK_HZ / 1000;

endpackage

// File: rtl/hcsr04_echo_emulator_if.sv
// Trigger/echo bundle between the ranging controller (master) and the sensor
// or its emulator (slave), plus the emulator's distance/presence inputs.
interface hcsr04_echo_emulator_if;

  logic        trig;
  logic [15:0] distance_mm;
  logic        obj_present;
  logic        echo;
  logic        busy;
  logic        trig_err;

  modport master (
    output trig,
    output distance_mm,
    output obj_present,
    input  echo,
    input  busy,
    input  trig_err
  );

  modport slave (
    input  trig,
    input  distance_mm,
    input  obj_present,
    output echo,
    output busy,
    output trig_err
  );

endinterface

// File: rtl/hcsr04_div34.sv
// Serial restoring divider by SCALE_DEN, one quotient bit per cycle; done stays
// high from completion until the next start.
module hcsr04_div34
  import hcsr04_pkg::*;
(
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  output logic [QUO_W-1:0] quotient,
  output logic             done
);

  localparam int REM_W   = $clog2(SCALE_DEN);
  localparam int TRIAL_W = REM_W + 1;
  localparam int CNT_W   = $clog2(NUM_W);

  logic [NUM_W-1:0]   num_q, num_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [QUO_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic [TRIAL_W-1:0] trial;
  logic               fits;

  always_comb begin
    trial  = {rem_q, num_q[NUM_W-1]};
    fits   = (trial >= TRIAL_W'(SCALE_DEN));
    num_d  = num_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = done_q;
    if (start) begin
      num_d  = numerator;
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      num_d = {num_q[NUM_W-2:0], 1'b0};
      rem_d = fits ? REM_W'(trial - TRIAL_W'(SCALE_DEN)) : trial[REM_W-1:0];
      // Quotient never exceeds QUO_W bits for in-range numerators, so the
      // leading bits shifted out of quo_q are always zero.
      quo_d = {quo_q[QUO_W-2:0], fits};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(NUM_W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      num_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: validates trig width, waits the burst delay, then drives an
// echo whose width encodes distance_mm. Optional echo jitter: HCSR04_EMU_JITTER_EN.
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int MIN_TRIG_CYCLES     = DEF_MIN_TRIG_CYCLES,
  parameter int BURST_DELAY_CYCLES  = DEF_BURST_DELAY_CYCLES,
  parameter int MAX_DIST_MM         = DEF_MAX_DIST_MM,
  parameter int TIMEOUT_ECHO_CYCLES = DEF_TIMEOUT_ECHO_CYCLES,
  parameter int HOLDOFF_CYCLES      = DEF_HOLDOFF_CYCLES
) (
  input logic                   clk_50M,
  input logic                   reset,
  hcsr04_echo_emulator_if.slave bus
);

  // state     | meaning
  // IDLE      | waiting for a synchronized trig rise
  // TRIG_HIGH | measuring trig high time
  // BURST     | burst delay after a valid trig, divider running
  // ECHO      | echo driven high for echo_cnt cycles
  // HOLDOFF   | dead time before re-arming, busy still high

  localparam int TRIG_W  = $clog2(MIN_TRIG_CYCLES + 1);
  localparam int BURST_W = $clog2(BURST_DELAY_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [15:0] MAX_D = 16'(MAX_DIST_MM);

  state_e              state_q, state_d;
  logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [QUO_W-1:0]    echo_cnt_q, echo_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [15:0]         dist_q, dist_d;
  logic                obj_q, obj_d;
  logic                echo_q, echo_d;
  logic                busy_q, busy_d;
  logic                trig_err_q, trig_err_d;
  logic                div_start_q, div_start_d;
  logic                trig_meta_q, trig_sync_q, trig_prev_q;
  logic                trig_rise, trig_fall, accept;
  logic [NUM_W-1:0]    div_numerator;
  logic [QUO_W-1:0]    div_quotient;
  logic                div_done;
  logic [QUO_W-1:0]    base_width, echo_width, jitter;

  assign trig_rise = trig_sync_q & ~trig_prev_q;
  assign trig_fall = ~trig_sync_q & trig_prev_q;

  // +SCALE_DEN-1 turns the floor division into ceil(d*SCALE_NUM/SCALE_DEN)
  assign div_numerator = NUM_W'(dist_q) * NUM_W'(SCALE_NUM) + NUM_W'(SCALE_DEN - 1);

  hcsr04_div34 u_div (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .start     (div_start_q),
    .numerator (div_numerator),
    .quotient  (div_quotient),
    .done      (div_done)
  );

  always_comb begin
    if (!obj_q || (dist_q > MAX_D)) begin
      base_width = QUO_W'(TIMEOUT_ECHO_CYCLES);
    end else if (dist_q == '0) begin
      base_width = QUO_W'(1);
    end else begin
      base_width = div_quotient;
    end
    echo_width = base_width + jitter;
  end

  always_comb begin
    state_d     = state_q;
    trig_cnt_d  = trig_cnt_q;
    burst_cnt_d = burst_cnt_q;
    echo_cnt_d  = echo_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    dist_d      = dist_q;
    obj_d       = obj_q;
    echo_d      = echo_q;
    busy_d      = busy_q;
    trig_err_d  = 1'b0;
    div_start_d = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        // The rise cycle is the first synchronized high cycle, hence the count of 1.
        if (trig_rise) begin
          state_d    = TRIG_HIGH;
          trig_cnt_d = TRIG_W'(1);
        end
      end
      TRIG_HIGH: begin
        if (trig_fall) begin
          if (trig_cnt_q >= TRIG_W'(MIN_TRIG_CYCLES)) begin
            accept      = 1'b1;
            dist_d      = bus.distance_mm;
            obj_d       = bus.obj_present;
            busy_d      = 1'b1;
            div_start_d = 1'b1;
            burst_cnt_d = BURST_W'(BURST_DELAY_CYCLES - 1);
            state_d     = BURST;
          end else begin
            trig_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else if (trig_cnt_q < TRIG_W'(MIN_TRIG_CYCLES)) begin
          trig_cnt_d = trig_cnt_q + TRIG_W'(1);
        end
      end
      BURST: begin
        if (burst_cnt_q != '0) begin
          burst_cnt_d = burst_cnt_q - BURST_W'(1);
        end else if (div_done) begin
          echo_d     = 1'b1;
          echo_cnt_d = echo_width - QUO_W'(1);
          state_d    = ECHO;
        end
      end
      ECHO: begin
        if (echo_cnt_q == '0) begin
          echo_d     = 1'b0;
          hold_cnt_d = HOLD_W'(HOLDOFF_CYCLES - 1);
          state_d    = HOLDOFF;
        end else begin
          echo_cnt_d = echo_cnt_q - QUO_W'(1);
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
      state_q     <= IDLE;
      trig_cnt_q  <= '0;
      burst_cnt_q <= '0;
      echo_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      dist_q      <= '0;
      obj_q       <= 1'b0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      trig_meta_q <= bus.trig;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
      state_q     <= state_d;
      trig_cnt_q  <= trig_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      echo_cnt_q  <= echo_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      dist_q      <= dist_d;
      obj_q       <= obj_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      trig_err_q  <= trig_err_d;
      div_start_q <= div_start_d;
    end
  end

`ifdef HCSR04_EMU_JITTER_EN
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci x^8+x^6+x^5+x^4+1, stepped once per accepted trigger
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign jitter = QUO_W'(lfsr_q[3:0]);
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign jitter        = '0;
`endif

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = trig_err_q;

endmodule
